// File: rtl/symbol_upsampler_if.sv
// symbol_upsampler_if
// Bundles the enable strobes and the registered outputs of symbol_upsampler.
//   sam_clk_ena  one-cycle sample enable (1 in 4 sys_clk)
//   sym_clk_ena  one-cycle symbol enable (1 in 16 sys_clk, coincides with a sample enable)
//   sym_out      current symbol bits {b1,b0}
//   sample_out   upsampled 1s17 sample
//   sam_phase    sample index within the symbol, 0 = symbol-carrying sample
//   sym_count    symbols issued since reset, wraps
// Modports: master drives the enables and observes the outputs (clock-enable
// generator / filter side); slave is the upsampler itself.
`timescale 1ns/1ps

interface symbol_upsampler_if;
    logic               sam_clk_ena;
    logic               sym_clk_ena;
    logic [1:0]         sym_out;
    logic signed [17:0] sample_out;
    logic [1:0]         sam_phase;
    logic [15:0]        sym_count;

    modport master (
        output sam_clk_ena,
        output sym_clk_ena,
        input  sym_out,
        input  sample_out,
        input  sam_phase,
        input  sym_count
    );

    modport slave (
        input  sam_clk_ena,
        input  sym_clk_ena,
        output sym_out,
        output sample_out,
        output sam_phase,
        output sym_count
    );
endinterface

// File: rtl/symbol_upsampler.sv
// symbol_upsampler
// Baseband symbol source and 4x upsampler for the transmit path. A 15-bit
// PRBS (x^15+x^14+1) supplies two bits per symbol, which are Gray-mapped to
// a 4-ASK level and emitted once per symbol; the other three samples of the
// symbol are zero-stuffed.
// Ports:
//   sys_clk  system clock, all logic on its rising edge
//   reset    asynchronous active-high reset
//   bus      symbol_upsampler_if.slave (enables in, registered outputs out)
// Parameters:
//   AMP      inner level magnitude in 1s17 (outer level is 3*AMP, AMP <= 43690)
//   SEED     PRBS state loaded at reset
// Configuration macro:
//   SYM_HOLD_EN  when defined, sample-only events repeat the current symbol's
//                level (sample-and-hold) instead of inserting zeros.
`timescale 1ns/1ps

module symbol_upsampler #(
    parameter logic signed [17:0] AMP  = 18'sd16384,
    parameter logic [14:0]        SEED = 15'h0001
) (
    input  logic              sys_clk,
    input  logic              reset,
    symbol_upsampler_if.slave bus
);

    localparam logic signed [17:0] AMP3 = 18'(3 * AMP);

    logic [14:0]        lfsr;
    logic [1:0]         sym_q;
    logic signed [17:0] sample_q;
    logic [1:0]         phase_q;
    logic [15:0]        sym_count_q;
`ifdef SYM_HOLD_EN
    logic signed [17:0] held_q;
`endif

    logic               bit1;
    logic               bit0;
    logic [14:0]        step1;
    logic [14:0]        step2;
    logic [14:0]        next_lfsr;
    logic [1:0]         next_sym;
    logic signed [17:0] next_level;

    // Two LFSR steps per symbol, unrolled so both bits come out in one cycle.
    // An all-zero state would lock the register forever, so it is replaced by
    // 15'h0001 and that symbol is forced to 2'b00.
    always_comb begin
        bit1      = lfsr[14] ^ lfsr[13];
        step1     = {lfsr[13:0], bit1};
        bit0      = step1[14] ^ step1[13];
        step2     = {step1[13:0], bit0};
        next_lfsr = step2;
        next_sym  = {bit1, bit0};
        if (lfsr == 15'h0000) begin
            next_lfsr = 15'h0001;
            next_sym  = 2'b00;
        end
    end

    // Gray-coded 4-ASK map: neighbouring levels differ in one bit.
    always_comb begin
        next_level = -AMP3;
        case (next_sym)
            2'b00: next_level = -AMP3;
            2'b01: next_level = -AMP;
            2'b11: next_level = AMP;
            2'b10: next_level = AMP3;
            default: next_level = -AMP3;
        endcase
    end

    // Symbol events take priority over a coincident sample enable: they load
    // the new symbol, its level and restart the phase. Sample-only events
    // only advance the phase and stuff a zero (or repeat the held level).
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            lfsr        <= SEED;
            sym_q       <= 2'b00;
            sample_q    <= '0;
            phase_q     <= 2'd0;
            sym_count_q <= 16'd0;
`ifdef SYM_HOLD_EN
            held_q      <= '0;
`endif
        end else if (bus.sym_clk_ena) begin
            lfsr        <= next_lfsr;
            sym_q       <= next_sym;
            sample_q    <= next_level;
            phase_q     <= 2'd0;
            sym_count_q <= sym_count_q + 16'd1;
`ifdef SYM_HOLD_EN
            held_q      <= next_level;
`endif
        end else if (bus.sam_clk_ena) begin
            phase_q     <= phase_q + 2'd1;
`ifdef SYM_HOLD_EN
            sample_q    <= held_q;
`else
            sample_q    <= '0;
`endif
        end
    end

    assign bus.sym_out    = sym_q;
    assign bus.sample_out = sample_q;
    assign bus.sam_phase  = phase_q;
    assign bus.sym_count  = sym_count_q;

endmodule

// File: tb/tb_symbol_upsampler.sv
// tb_symbol_upsampler
// Directed bench for symbol_upsampler. Two instances share clock, reset and
// enables: dut_a uses the default SEED (15'h0001), dut_b uses SEED 0 to hit
// the lock-up guard. Expected symbols come from a software PRBS model and
// hand-derived constants. Honours SYM_HOLD_EN for the sample-only values.
`timescale 1ns/1ps

module tb_symbol_upsampler;

`ifdef SYM_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    localparam logic signed [17:0] LVL_N3 = -18'sd49152;
    localparam logic signed [17:0] LVL_N1 = -18'sd16384;
    localparam logic signed [17:0] LVL_P1 = 18'sd16384;
    localparam logic signed [17:0] LVL_P3 = 18'sd49152;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;

    int passed = 0;
    int total  = 0;

    logic [14:0]        model_lfsr;
    logic signed [17:0] cur_level;

    symbol_upsampler_if bus_a ();
    symbol_upsampler_if bus_b ();

    assign bus_b.sam_clk_ena = bus_a.sam_clk_ena;
    assign bus_b.sym_clk_ena = bus_a.sym_clk_ena;

    symbol_upsampler #(.AMP(18'sd16384), .SEED(15'h0001)) dut_a (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus_a.slave)
    );

    symbol_upsampler #(.AMP(18'sd16384), .SEED(15'h0000)) dut_b (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus_b.slave)
    );

    always #20 sys_clk = ~sys_clk;

    function automatic logic signed [17:0] level_of(input logic [1:0] s);
        case (s)
            2'b00:   return LVL_N3;
            2'b01:   return LVL_N1;
            2'b11:   return LVL_P1;
            default: return LVL_P3;
        endcase
    endfunction

    // Software PRBS: two Fibonacci steps per symbol, first new bit is b1.
    task automatic model_next(output logic [1:0] s);
        logic b1, b0;
        if (model_lfsr == 15'h0000) begin
            model_lfsr = 15'h0001;
            s = 2'b00;
        end else begin
            b1 = model_lfsr[14] ^ model_lfsr[13];
            model_lfsr = {model_lfsr[13:0], b1};
            b0 = model_lfsr[14] ^ model_lfsr[13];
            model_lfsr = {model_lfsr[13:0], b0};
            s = {b1, b0};
        end
    endtask

    // One sys_clk cycle with the given enables; outputs are settled on return.
    task automatic cycle(input logic sam, input logic sym);
        @(negedge sys_clk);
        bus_a.sam_clk_ena = sam;
        bus_a.sym_clk_ena = sym;
        @(posedge sys_clk);
        #1;
        bus_a.sam_clk_ena = 1'b0;
        bus_a.sym_clk_ena = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge sys_clk);
        #5 reset = 1'b1;
        @(negedge sys_clk);
        reset = 1'b0;
        model_lfsr = 15'h0001;
        cur_level  = '0;
    endtask

    task automatic test_reset();
        bus_a.sam_clk_ena = 1'b0;
        bus_a.sym_clk_ena = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        reset = 1'b0;
        model_lfsr = 15'h0001;
        cur_level  = '0;
        #1;
        total++; if (dut_a.lfsr !== 15'h0001) $display("FAIL reset_lfsr_a got %h want 0001", dut_a.lfsr); else passed++;
        total++; if (dut_b.lfsr !== 15'h0000) $display("FAIL reset_lfsr_b got %h want 0000", dut_b.lfsr); else passed++;
        total++; if (bus_a.sym_out !== 2'b00) $display("FAIL reset_sym got %b want 00", bus_a.sym_out); else passed++;
        total++; if (bus_a.sample_out !== 18'sd0) $display("FAIL reset_sample got %0d want 0", bus_a.sample_out); else passed++;
        total++; if (bus_a.sam_phase !== 2'd0) $display("FAIL reset_phase got %0d want 0", bus_a.sam_phase); else passed++;
        total++; if (bus_a.sym_count !== 16'd0) $display("FAIL reset_count got %0d want 0", bus_a.sym_count); else passed++;
    endtask

    // Standard pattern up to the first symbol: samples before it read 0 in
    // both modes, then the first symbol from SEED 1 is 00 at -49152.
    task automatic test_first_symbol();
        logic [1:0] s;
        for (int p = 0; p < 16; p++) begin
            cycle((p % 4) == 3, p == 15);
            if ((p % 4) == 3 && p != 15) begin
                total++; if (bus_a.sample_out !== 18'sd0) $display("FAIL pre_sym_sample p%0d got %0d want 0", p, bus_a.sample_out); else passed++;
                total++; if (bus_a.sam_phase !== 2'((p + 1) / 4)) $display("FAIL pre_sym_phase p%0d got %0d want %0d", p, bus_a.sam_phase, (p + 1) / 4); else passed++;
            end
        end
        model_next(s);
        cur_level = level_of(s);
        total++; if (dut_a.lfsr !== 15'h0004) $display("FAIL first_lfsr got %h want 0004", dut_a.lfsr); else passed++;
        total++; if (bus_a.sym_out !== 2'b00) $display("FAIL first_sym got %b want 00", bus_a.sym_out); else passed++;
        total++; if (bus_a.sample_out !== LVL_N3) $display("FAIL first_sample got %h want 34000", bus_a.sample_out); else passed++;
        total++; if (bus_a.sam_phase !== 2'd0) $display("FAIL first_phase got %0d want 0", bus_a.sam_phase); else passed++;
        total++; if (bus_a.sym_count !== 16'd1) $display("FAIL first_count got %0d want 1", bus_a.sym_count); else passed++;
        total++; if (dut_b.lfsr !== 15'h0001) $display("FAIL seed0_lfsr got %h want 0001", dut_b.lfsr); else passed++;
        total++; if (bus_b.sym_out !== 2'b00) $display("FAIL seed0_sym got %b want 00", bus_b.sym_out); else passed++;
        total++; if (bus_b.sample_out !== LVL_N3) $display("FAIL seed0_sample got %0d want -49152", bus_b.sample_out); else passed++;
    endtask

    // Eight further symbols with the standard enable pattern.
    task automatic test_standard_pattern();
        logic [1:0]         s;
        logic signed [17:0] exp_zero;
        for (int n = 0; n < 8; n++) begin
            for (int p = 0; p < 16; p++) begin
                cycle((p % 4) == 3, p == 15);
                exp_zero = HOLD ? cur_level : 18'sd0;
                if (p == 0) begin
                    total++; if (bus_a.sample_out !== cur_level) $display("FAIL idle_hold n%0d got %0d want %0d", n, bus_a.sample_out, cur_level); else passed++;
                end else if (p == 15) begin
                    model_next(s);
                    cur_level = level_of(s);
                    total++; if (bus_a.sym_out !== s) $display("FAIL std_sym n%0d got %b want %b", n, bus_a.sym_out, s); else passed++;
                    total++; if (bus_a.sample_out !== cur_level) $display("FAIL std_level n%0d got %0d want %0d", n, bus_a.sample_out, cur_level); else passed++;
                    total++; if (bus_a.sam_phase !== 2'd0) $display("FAIL std_phase0 n%0d got %0d want 0", n, bus_a.sam_phase); else passed++;
                    total++; if (bus_a.sym_count !== 16'(n + 2)) $display("FAIL std_count n%0d got %0d want %0d", n, bus_a.sym_count, n + 2); else passed++;
                end else if ((p % 4) == 3) begin
                    total++; if (bus_a.sample_out !== exp_zero) $display("FAIL std_stuff n%0d p%0d got %0d want %0d", n, p, bus_a.sample_out, exp_zero); else passed++;
                    total++; if (bus_a.sam_phase !== 2'((p + 1) / 4)) $display("FAIL std_phase n%0d p%0d got %0d want %0d", n, p, bus_a.sam_phase, (p + 1) / 4); else passed++;
                end
            end
        end
    endtask

    // Reset asserted between samples 2 and 3 of a symbol, away from any edge.
    task automatic test_reset_mid_symbol();
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        @(negedge sys_clk);
        #5 reset = 1'b1;
        #1;
        total++; if (bus_a.sample_out !== 18'sd0) $display("FAIL async_sample got %0d want 0", bus_a.sample_out); else passed++;
        total++; if (bus_a.sam_phase !== 2'd0) $display("FAIL async_phase got %0d want 0", bus_a.sam_phase); else passed++;
        total++; if (bus_a.sym_count !== 16'd0) $display("FAIL async_count got %0d want 0", bus_a.sym_count); else passed++;
        total++; if (bus_a.sym_out !== 2'b00) $display("FAIL async_sym got %b want 00", bus_a.sym_out); else passed++;
        total++; if (dut_a.lfsr !== 15'h0001) $display("FAIL async_lfsr got %h want 0001", dut_a.lfsr); else passed++;
        @(negedge sys_clk);
        reset = 1'b0;
        model_lfsr = 15'h0001;
        cur_level  = '0;
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b1, 1'b0);
            total++; if (bus_a.sample_out !== 18'sd0) $display("FAIL post_rst_sample k%0d got %0d want 0", k, bus_a.sample_out); else passed++;
            total++; if (bus_a.sam_phase !== 2'(k)) $display("FAIL post_rst_phase k%0d got %0d want %0d", k, bus_a.sam_phase, k); else passed++;
        end
        cycle(1'b1, 1'b1);
        total++; if (bus_a.sample_out !== LVL_N3) $display("FAIL post_rst_first got %0d want -49152", bus_a.sample_out); else passed++;
        total++; if (bus_a.sym_count !== 16'd1) $display("FAIL post_rst_count got %0d want 1", bus_a.sym_count); else passed++;
    endtask

    // 16383 symbols back to back (32766 steps). The register period is 32767
    // steps, so the state lands one step short of SEED: 15'h4000.
    task automatic test_long_run();
        int         dut_hist [4];
        int         model_hist [4];
        int         bad;
        logic [1:0] s;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            dut_hist[i]   = 0;
            model_hist[i] = 0;
        end
        bad = 0;
        for (int n = 0; n < 16383; n++) begin
            cycle(1'b1, 1'b1);
            model_next(s);
            model_hist[s]++;
            dut_hist[bus_a.sym_out]++;
            if (bus_a.sym_out !== s) bad++;
        end
        total++; if (bad != 0) $display("FAIL long_seq got %0d wrong symbols want 0", bad); else passed++;
        total++; if (dut_a.lfsr !== 15'h4000) $display("FAIL long_lfsr got %h want 4000", dut_a.lfsr); else passed++;
        total++; if (bus_a.sym_count !== 16'd16383) $display("FAIL long_count got %0d want 16383", bus_a.sym_count); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ((dut_hist[i] - model_hist[i] > 1) || (model_hist[i] - dut_hist[i] > 1))
                $display("FAIL long_hist sym%0d got %0d want %0d", i, dut_hist[i], model_hist[i]);
            else passed++;
        end
    endtask

    task automatic test_count_wrap();
        @(negedge sys_clk);
        force dut_a.sym_count_q = 16'hFFFF;
        @(negedge sys_clk);
        release dut_a.sym_count_q;
        #1;
        total++; if (bus_a.sym_count !== 16'hFFFF) $display("FAIL wrap_preload got %h want ffff", bus_a.sym_count); else passed++;
        cycle(1'b1, 1'b1);
        total++; if (bus_a.sym_count !== 16'h0000) $display("FAIL wrap_count got %h want 0000", bus_a.sym_count); else passed++;
    endtask

    initial begin
        test_reset();
        test_first_symbol();
        test_standard_pattern();
        test_reset_mid_symbol();
        test_long_run();
        test_count_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
